// File: rtl/ab_diff_tracker.sv
// Saturating signed (#A - #B) event difference with equality/lead flags and a sticky saturation flag.
// EDGE_MODE selects level sampling (0) or rising-edge sampling (1) of the event inputs.
module ab_diff_tracker #(
   parameter  int MAX_DIFF  = 7,
   parameter  int EDGE_MODE = 0,
   localparam int DW        = $clog2(MAX_DIFF + 1) + 1
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 inA,
   input  logic                 inB,
   output logic signed [DW-1:0] diff,
   output logic                 AeqB,
   output logic                 AmB,
   output logic                 BmA,
   output logic                 sat
);

   localparam logic signed [DW-1:0] DIFF_MAX = DW'(MAX_DIFF);
   localparam logic signed [DW-1:0] DIFF_MIN = -DIFF_MAX;
   localparam logic signed [DW-1:0] ONE      = DW'(1);
   localparam logic signed [DW-1:0] ZERO     = '0;

   logic                 ev_a;
   logic                 ev_b;
   logic                 step_up;
   logic                 step_dn;
   logic signed [DW-1:0] diff_q;
   logic signed [DW-1:0] diff_d;
   logic                 sat_q;
   logic                 sat_d;

   if (EDGE_MODE != 0) begin : g_edge
      logic ina_q;
      logic inb_q;

      // Previous-input registers keep tracking through clr, so an input held
      // across a clear does not produce a fresh edge afterwards.
      always_ff @(posedge CLK or posedge rst) begin
         if (rst) begin
            ina_q <= 1'b0;
            inb_q <= 1'b0;
         end else begin
            ina_q <= inA;
            inb_q <= inB;
         end
      end

      assign ev_a = inA & ~ina_q;
      assign ev_b = inB & ~inb_q;
   end else begin : g_level
      assign ev_a = inA;
      assign ev_b = inB;
   end

   assign step_up = ev_a & ~ev_b;
   assign step_dn = ev_b & ~ev_a;

   always_comb begin
      // NOTE: defaults first so every path assigns diff_d/sat_d and no latch is inferred.
      diff_d = diff_q;
      sat_d  = sat_q;
      if (clr) begin
         diff_d = ZERO;
         sat_d  = 1'b0;
      end else if (step_up) begin
         if (diff_q == DIFF_MAX) sat_d  = 1'b1;
         else                    diff_d = diff_q + ONE;
      end else if (step_dn) begin
         if (diff_q == DIFF_MIN) sat_d  = 1'b1;
         else                    diff_d = diff_q - ONE;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         diff_q <= ZERO;
         sat_q  <= 1'b0;
      end else begin
         diff_q <= diff_d;
         sat_q  <= sat_d;
      end
   end

   // Flags decode the registered difference, so exactly one is ever high.
   assign diff = diff_q;
   assign sat  = sat_q;
   assign AeqB = (diff_q == ZERO);
   assign BmA  = diff_q[DW-1];
   assign AmB  = ~AeqB & ~BmA;

endmodule
